key_conditioner: RTL and testbench



---
 rtl/key_conditioner_if.sv | 28 ++
 rtl/key_conditioner.sv | 119 +++++++++++
 tb/tb_key_conditioner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/key_conditioner_if.sv
// Push-button bundle between the board keys and the conditioner.
// master drives the raw levels; slave returns the conditioned levels and pulses.
`timescale 1ns/1ps
interface key_conditioner_if #(
  parameter int N_KEYS = 3
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              any_press;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  any_press
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release,
    output any_press
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer and one-cycle press/release pulse generator.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key stays held.
`timescale 1ns/1ps
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  key_conditioner_if.slave kif
);
  localparam int                CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]     DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] RELEASED = {N_KEYS{(ACTIVE_LOW != 0)}};

`ifdef KEY_REPEAT_EN
  localparam int            RMAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW       = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_conditioner: illegal parameter value");
  end

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] norm;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_p;

  // Two-flop synchroniser; reset parks both stages at the released level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= kif.key_raw;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ RELEASED;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [CW-1:0] cnt;
    logic          lvl_q;
    logic          lvl_d;
    logic          press_q;
    logic          release_q;
    logic          accept;
    logic          lvl_nxt;
    logic          rep_fire;

    always_comb begin
      accept  = (norm[k] != lvl_q) && (cnt == DB_LAST);
      lvl_nxt = lvl_q ^ accept;
    end

    // Debounce counter, accepted level and registered edge pulses
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt       <= '0;
        lvl_q     <= 1'b0;
        lvl_d     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if (norm[k] == lvl_q || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        lvl_q     <= lvl_nxt;
        lvl_d     <= lvl_q;
        press_q   <= (lvl_q & ~lvl_d) | rep_fire;
        release_q <= ~lvl_q & lvl_d;
      end
    end

`ifdef KEY_REPEAT_EN
    logic [RW-1:0] rep_cnt;
    logic          rep_armed;
    logic          held;

    // Held means pressed, past the initial press pulse, and not releasing this edge
    assign held     = lvl_q & lvl_d & lvl_nxt;
    assign rep_fire = held && (rep_cnt == (rep_armed ? PER_LAST : DLY_LAST));

    always_ff @(posedge clk) begin
      if (reset || !held) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign level[k]     = lvl_q;
    assign press[k]     = press_q;
    assign release_p[k] = release_q;
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press;
  assign kif.key_release = release_p;
  assign kif.any_press   = |press;
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, active-low keys.
`timescale 1ns/1ps
module tb_key_conditioner;
  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  key_conditioner_if #(.N_KEYS(3)) kif ();

  key_conditioner #(
    .N_KEYS          (3),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] lvl, input logic [2:0] prs,
                         input logic [2:0] rel, input logic anyp);
    chk({tag, ".level"},   kif.key_level,   lvl);
    chk({tag, ".press"},   kif.key_press,   prs);
    chk({tag, ".release"}, kif.key_release, rel);
    chk({tag, ".any"},     {2'b00, kif.any_press}, {2'b00, anyp});
  endtask

  initial begin
    logic [2:0] exp_press;
    reset       = 1'b1;
    kif.key_raw = 3'b111;
    step(3);
    chk_all("reset", 3'b000, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    step(3);
    chk_all("idle", 3'b000, 3'b000, 3'b000, 1'b0);

    // Clean press of key 1: level at edge 6, pulse at edge 7
    kif.key_raw = 3'b101;
    step(5);
    chk("press1.e5.level", kif.key_level, 3'b000);
    step(1);
    chk_all("press1.e6", 3'b010, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_all("press1.e7", 3'b010, 3'b010, 3'b000, 1'b1);
    step(1);
    chk_all("press1.e8", 3'b010, 3'b000, 3'b000, 1'b0);

    // Release of key 1
    kif.key_raw = 3'b111;
    step(5);
    chk("rel1.e5.level", kif.key_level, 3'b010);
    step(1);
    chk_all("rel1.e6", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_all("rel1.e7", 3'b000, 3'b000, 3'b010, 1'b0);
    step(1);
    chk_all("rel1.e8", 3'b000, 3'b000, 3'b000, 1'b0);

    // Bounce on key 0: ten single-cycle toggles, then held low
    for (int i = 0; i < 10; i++) begin
      kif.key_raw = {2'b11, i[0]};
      step(1);
      chk("bounce.press", kif.key_press, 3'b000);
    end
    kif.key_raw = 3'b110;
    step(6);
    chk_all("bounce.e6", 3'b001, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_all("bounce.e7", 3'b001, 3'b001, 3'b000, 1'b1);
    step(1);
    chk("bounce.e8.press", kif.key_press, 3'b000);
    kif.key_raw = 3'b111;
    step(7);
    chk_all("bounce.rel", 3'b000, 3'b000, 3'b001, 1'b0);

    // Glitch on key 2 shorter than the debounce window
    kif.key_raw = 3'b011;
    step(3);
    kif.key_raw = 3'b111;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch.press", kif.key_press, 3'b000);
    end
    chk("glitch.level", kif.key_level, 3'b000);

    // Reset two counts into a debounce, key still held afterwards
    kif.key_raw = 3'b101;
    step(4);
    reset = 1'b1;
    step(2);
    chk_all("midrst", 3'b000, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    step(6);
    chk_all("midrst.e6", 3'b010, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_all("midrst.e7", 3'b010, 3'b010, 3'b000, 1'b1);
    kif.key_raw = 3'b111;
    step(8);
    chk_all("midrst.idle", 3'b000, 3'b000, 3'b000, 1'b0);

    // Keys 0 and 2 together, then held for 20 cycles after acceptance
    kif.key_raw = 3'b010;
    step(6);
    chk_all("simul.e6", 3'b101, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_all("simul.e7", 3'b101, 3'b101, 3'b000, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      step(1);
      exp_press = 3'b000;
`ifdef KEY_REPEAT_EN
      if (i == 8 || i == 12 || i == 16 || i == 20) exp_press = 3'b101;
`endif
      chk("hold.press", kif.key_press, exp_press);
      chk("hold.any", {2'b00, kif.any_press}, {2'b00, (exp_press != 3'b000)});
    end
    kif.key_raw = 3'b111;
    step(6);
    chk_all("relboth.e6", 3'b000, 3'b000, 3'b000, 1'b0);
    step(1);
    chk_all("relboth.e7", 3'b000, 3'b000, 3'b101, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("after.press", kif.key_press, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
